// File: rtl/stepper_pkg.sv
// Shared types and defaults for the single-step / free-run pipeline controller.
package stepper_pkg;

  localparam int unsigned STATE_W             = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000;
  localparam int unsigned CNT_W_DEF           = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes a raw push button and accepts a level change only after
// DEBOUNCE_CYCLES consecutive samples of the new value; flags debounced rises.
module btn_debounce
  import stepper_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic CLOCK_50,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            rise_q, rise_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  // cnt_q counts consecutive samples that disagree with the accepted level
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_LAST) begin
      level_d = sync2_q;
      rise_d  = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/cycle_stepper.sv
// Pipeline clock-enable controller: free-run on divider ticks, single-step on a
// debounced button, halt on request; counts issued pipeline advances.
module cycle_stepper
  import stepper_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic               CLOCK_50,
  input  logic               rst_n,
  input  logic               tickIn,
  input  logic               run,
  input  logic               stepBtn,
  input  logic               haltReq,
  input  logic               clr,
  output logic               pipeEn,
  output logic               stop,
  output logic [CNT_W-1:0]   cycleCount,
  output logic               ovf,
  output logic [STATE_W-1:0] state
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             tick_s1_q, tick_s2_q, tick_s3_q;
  logic             tick_rise_c;
  logic             step_level, step_rise;
  logic             press_c;
  logic             pulse_c;
  state_e           state_q, state_d;
  logic             pipe_en_q, pipe_en_d;
  logic             stop_q, stop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .CLOCK_50(CLOCK_50),
    .rst_n   (rst_n),
    .raw     (stepBtn),
    .level   (step_level),
    .rise    (step_rise)
  );

  // A press is only honoured while the debounced level is still high
  assign press_c     = step_rise & step_level;
  assign tick_rise_c = tick_s2_q & ~tick_s3_q;

  always_comb begin
    state_d   = state_q;
    pipe_en_d = 1'b0;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    pulse_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run)          state_d = ST_RUN;
        else if (press_c) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (haltReq)          state_d = ST_HALTED;
        else if (!run)        state_d = ST_IDLE;
        else if (tick_rise_c) pulse_c = 1'b1;
      end
      ST_STEP: begin
        if (haltReq) begin
          state_d = ST_HALTED;
        end else if (tick_rise_c) begin
          pulse_c = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_HALTED: begin
        if (clr) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Saturating advance counter; pulses keep flowing after saturation
    if (pulse_c) begin
      pipe_en_d = 1'b1;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      ovf_d = ovf_q | (cnt_d == CNT_MAX);
    end
    stop_d = (state_d == ST_IDLE) || (state_d == ST_HALTED);
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      tick_s1_q <= 1'b0;
      tick_s2_q <= 1'b0;
      tick_s3_q <= 1'b0;
      state_q   <= ST_IDLE;
      pipe_en_q <= 1'b0;
      stop_q    <= 1'b1;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      tick_s1_q <= tickIn;
      tick_s2_q <= tick_s1_q;
      tick_s3_q <= tick_s2_q;
      state_q   <= state_d;
      pipe_en_q <= pipe_en_d;
      stop_q    <= stop_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  assign pipeEn     = pipe_en_q;
  assign stop       = stop_q;
  assign cycleCount = cnt_q;
  assign ovf        = ovf_q;
  assign state      = state_q;

endmodule

// File: tb/tb_cycle_stepper.sv
// Scoreboard bench for cycle_stepper: expected pulses are queued when a tick is
// driven and matched (cycle, count, overflow) when pipeEn is seen.
module tb_cycle_stepper;

  localparam int unsigned DEB = 4;
  localparam int unsigned CW  = 4;

  logic          CLOCK_50 = 1'b0;
  logic          rst_n;
  logic          tickIn, run, stepBtn, haltReq, clr;
  logic          pipeEn, stop, ovf;
  logic [CW-1:0] cycleCount;
  logic [1:0]    state;

  typedef struct {
    int unsigned cyc;
    int unsigned cnt;
    bit          ov;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  cycle_stepper #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CW)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .rst_n     (rst_n),
    .tickIn    (tickIn),
    .run       (run),
    .stepBtn   (stepBtn),
    .haltReq   (haltReq),
    .clr       (clr),
    .pipeEn    (pipeEn),
    .stop      (stop),
    .cycleCount(cycleCount),
    .ovf       (ovf),
    .state     (state)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse monitor: every pipeEn cycle must match the head of the scoreboard
  always @(posedge CLOCK_50) begin
    #1;
    if (pipeEn === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", 32'(pipeEn), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("pulse_cyc", cyc, e.cyc);
        check("pulse_cnt", 32'(cycleCount), e.cnt);
        check("pulse_ovf", 32'(ovf), 32'(e.ov));
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    rst_n = 1'b0;
    clks(2);
    rst_n = 1'b1;
  endtask

  task automatic tick(input bit exp_pulse, input int unsigned exp_cnt, input bit exp_ovf);
    @(negedge CLOCK_50);
    tickIn = 1'b1;
    if (exp_pulse) sb_q.push_back('{cyc: cyc + 3, cnt: exp_cnt, ov: exp_ovf});
    clks(10);
    tickIn = 1'b0;
    clks(9);
  endtask

  task automatic bouncy_press();
    @(negedge CLOCK_50); stepBtn = 1'b1;
    @(negedge CLOCK_50); stepBtn = 1'b0;
    @(negedge CLOCK_50); stepBtn = 1'b1;
    clks(6);
    stepBtn = 1'b0;
    clks(14);
  endtask

  initial begin
    rst_n = 1'b0; tickIn = 1'b0; run = 1'b0; stepBtn = 1'b0; haltReq = 1'b0; clr = 1'b0;
    clks(3);
    check("rst_state", 32'(state), 32'd0);
    check("rst_stop", 32'(stop), 32'd1);
    check("rst_pipeEn", 32'(pipeEn), 32'd0);
    check("rst_count", 32'(cycleCount), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    clks(2);

    // Free run, five ticks
    run = 1'b1;
    clks(1);
    check("run_state", 32'(state), 32'd1);
    check("run_stop", 32'(stop), 32'd0);
    for (int i = 1; i <= 5; i++) tick(1'b1, i, 1'b0);
    check("run_count", 32'(cycleCount), 32'd5);
    run = 1'b0;
    clks(2);
    check("run_exit_state", 32'(state), 32'd0);
    check("run_exit_stop", 32'(stop), 32'd1);
    tick(1'b0, 0, 1'b0);
    check("run_pending", 32'(sb_q.size()), 32'd0);

    // Bouncy single step
    do_reset();
    bouncy_press();
    check("step_state", 32'(state), 32'd2);
    check("step_stop", 32'(stop), 32'd0);
    tick(1'b1, 1, 1'b0);
    check("step_done_state", 32'(state), 32'd0);
    check("step_count", 32'(cycleCount), 32'd1);
    @(negedge CLOCK_50); clr = 1'b1;
    @(negedge CLOCK_50); clr = 1'b0;
    check("clr_idle_count", 32'(cycleCount), 32'd1);
    tick(1'b0, 0, 1'b0);
    check("step_pending", 32'(sb_q.size()), 32'd0);

    // Halt coincident with a tick edge
    do_reset();
    run = 1'b1;
    tick(1'b1, 1, 1'b0);
    @(negedge CLOCK_50);
    tickIn = 1'b1;
    clks(2);
    haltReq = 1'b1;
    @(negedge CLOCK_50);
    haltReq = 1'b0;
    check("halt_state", 32'(state), 32'd3);
    check("halt_stop", 32'(stop), 32'd1);
    clks(8);
    tickIn = 1'b0;
    clks(9);
    tick(1'b0, 0, 1'b0);
    check("halt_hold_state", 32'(state), 32'd3);
    check("halt_count", 32'(cycleCount), 32'd1);
    run = 1'b0;
    @(negedge CLOCK_50); clr = 1'b1;
    @(negedge CLOCK_50); clr = 1'b0;
    check("clr_state", 32'(state), 32'd0);
    check("clr_count", 32'(cycleCount), 32'd0);
    check("halt_pending", 32'(sb_q.size()), 32'd0);

    // Saturation
    do_reset();
    run = 1'b1;
    for (int i = 1; i <= 20; i++) tick(1'b1, (i > 15) ? 15 : i, i >= 15);
    check("sat_count", 32'(cycleCount), 32'd15);
    check("sat_ovf", 32'(ovf), 32'd1);
    run = 1'b0;
    clks(2);
    check("sat_pending", 32'(sb_q.size()), 32'd0);

    // Reset while a step waits for its tick
    do_reset();
    bouncy_press();
    check("rst_step_state", 32'(state), 32'd2);
    @(negedge CLOCK_50);
    rst_n = 1'b0;
    #1;
    check("rst_abort_state", 32'(state), 32'd0);
    check("rst_abort_stop", 32'(stop), 32'd1);
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    tick(1'b0, 0, 1'b0);
    check("rst_after_state", 32'(state), 32'd0);
    check("rst_after_count", 32'(cycleCount), 32'd0);
    check("rst_pending", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cycle_stepper.md
CYCLE_STEPPER -- requirements
Module: cycle_stepper

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000, meaning: CLOCK_50 cycles stepBtn must be stable before a level change is accepted.
REQ-002 Parameter CNT_W, default 16, meaning: width of cycleCount.
REQ-003 CLOCK_50  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 tickIn  input  1  divided slow clock from the upstream divider, asynchronous to CLOCK_50.
REQ-006 run  input  1  level; 1 requests free-running mode.
REQ-007 stepBtn  input  1  raw, bouncy, asynchronous single-step button, active-high.
REQ-008 haltReq  input  1  synchronous pipeline halt request, level.
REQ-009 clr  input  1  synchronous clear out of HALTED.
REQ-010 pipeEn  output  1  one-cycle pipeline advance enable.
REQ-011 stop  output  1  freeze request fed back to the divider's stop input.
REQ-012 cycleCount  output  CNT_W  number of pipeEn pulses issued.
REQ-013 ovf  output  1  sticky flag: cycleCount saturated.
REQ-014 state  output  2  current FSM state encoding.

Function
REQ-015 tickIn SHALL pass through a 2-flop synchronizer, then a registered rising-edge detect; edge = sync2 & ~sync3.
REQ-016 The FSM SHALL have the states IDLE=0, RUN=1, STEP=2 and HALTED=3.
REQ-017 IDLE: stop=1; run=1 -> RUN; otherwise an accepted step press -> STEP; run takes priority over a step press in the same cycle.
REQ-018 RUN: stop=0; each tick edge -> pipeEn=1 for exactly one cycle; run=0 -> IDLE with no further pulse.
REQ-019 STEP: stop=0; first tick edge -> exactly one pipeEn pulse, then IDLE in the same transition.
REQ-020 haltReq=1 in RUN or STEP -> HALTED next cycle; a tick edge in the same cycle SHALL NOT produce a pulse (halt wins).
REQ-021 HALTED: stop=1, pipeEn=0; run, stepBtn and haltReq are ignored; clr=1 -> IDLE and cycleCount=0, ovf=0.
REQ-022 clr in any state other than HALTED SHALL have no effect.
REQ-023 pipeEn SHALL be registered; latency is 3 rising edges, counted from the first edge that samples tickIn high.
REQ-024 cycleCount SHALL increment in the cycle pipeEn is high.
REQ-025 At 2^CNT_W-1, cycleCount SHALL hold and ovf SHALL set; pipeEn pulses continue.
REQ-026 stepBtn SHALL be synchronized, then debounced: the debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-027 A step press SHALL be the rising edge of the debounced level; presses outside IDLE are discarded, not queued.
REQ-028 stop SHALL be a registered output derived from the next state.

Reset
REQ-029 rst_n=0 SHALL immediately force: state=IDLE, pipeEn=0, stop=1, cycleCount=0, ovf=0, synchronizer and debounce registers=0.
REQ-030 A reset mid-STEP or mid-RUN SHALL abort with no pulse; after deassertion, the first accepted tick edge requires a fresh 0->1 transition of sync2.

Structure
REQ-031 A shared package stepper_pkg SHALL hold the state enum, the state encodings and the default parameter values.
REQ-032 Debounce SHALL be the sub-module btn_debounce (CLOCK_50, rst_n, raw, level, rise) with the DEBOUNCE_CYCLES parameter.
REQ-033 The edge detect and the FSM SHALL remain in cycle_stepper.

Verification (bench DEBOUNCE_CYCLES=4, CNT_W=4)
REQ-034 run=1, tickIn period 20 cycles, 5 ticks -> 5 single-cycle pipeEn pulses, each 3 edges after tickIn rises; cycleCount=5; stop=0 from the cycle after RUN entry.
REQ-035 IDLE, stepBtn bounces 1-0-1 at 1-cycle spacing, then held for 6 cycles -> exactly one press; one pulse on the next tick; state back to IDLE; cycleCount=1.
REQ-036 RUN, haltReq asserted in the same cycle as a tick edge -> no pulse; state=HALTED; stop=1; later ticks ignored; clr -> IDLE, cycleCount=0.
REQ-037 RUN for 20 ticks -> cycleCount holds at 15; ovf=1 from the 15th pulse; pulses continue.
REQ-038 rst_n pulsed low for 1 cycle while STEP awaits a tick -> immediate IDLE, stop=1, no pulse on the following tick.
